// File: rtl/control_sequencer.sv
// Registered ID-stage control decoder with LDM/STM micro-op expansion,
// a valid/ready output register and a synchronous flush.
module control_sequencer #(
    parameter int NREGS    = 16,
    parameter int REGIDX_W = 4,
    parameter int CMD_W    = 4,
    parameter int OFFS_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [3:0]          opcode,
    input  logic                S,
    input  logic [NREGS-1:0]    reg_list,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CMD_W-1:0]    exeCMD,
    output logic                S_UpdateSig,
    output logic                branch,
    output logic                memWriteEn,
    output logic                memReadEn,
    output logic                writeBackEn,
    output logic [REGIDX_W-1:0] uop_reg,
    output logic [OFFS_W-1:0]   uop_offset,
    output logic                uop_last,
    output logic                illegal,
    output logic                busy
);

    typedef enum logic {IDLE, SEQ} state_t;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic             s_upd;
        logic             br;
        logic             mem_wr;
        logic             mem_rd;
        logic             wb;
        logic             ill;
    } ctrl_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [REGIDX_W-1:0] reg_idx;
        logic [OFFS_W-1:0]   offs;
        logic                last;
    } uop_t;

    state_t             state_q, state_d;
    uop_t               uop_q, uop_d;
    logic               out_valid_q, out_valid_d;
    logic [NREGS-1:0]   rem_q, rem_d;
    logic [OFFS_W-1:0]  noff_q, noff_d;

    logic               slot_free;
    logic               accept;
    logic [NREGS-1:0]   rem_after;
    logic [NREGS-1:0]   list_after;

    function automatic logic [CMD_W-1:0] cmd_c(input logic [3:0] c);
        return CMD_W'(c);
    endfunction

    function automatic ctrl_t decode(input logic [1:0] m, input logic [3:0] op, input logic s);
        ctrl_t c;
        c = '0;
        case (m)
            2'b00: begin
                c.s_upd = s;
                c.wb    = 1'b1;
                case (op)
                    4'b1101: c.cmd = cmd_c(4'b0001);
                    4'b1111: c.cmd = cmd_c(4'b1001);
                    4'b0100: c.cmd = cmd_c(4'b0010);
                    4'b0101: c.cmd = cmd_c(4'b0011);
                    4'b0010: c.cmd = cmd_c(4'b0100);
                    4'b0110: c.cmd = cmd_c(4'b0101);
                    4'b0000: c.cmd = cmd_c(4'b0110);
                    4'b1100: c.cmd = cmd_c(4'b0111);
                    4'b0001: c.cmd = cmd_c(4'b1000);
                    4'b1010: begin
                        c.cmd   = cmd_c(4'b0100);
                        c.s_upd = 1'b1;
                        c.wb    = 1'b0;
                    end
                    4'b1000: begin
                        c.cmd   = cmd_c(4'b0110);
                        c.s_upd = 1'b1;
                        c.wb    = 1'b0;
                    end
                    default: begin
                        c     = '0;
                        c.ill = 1'b1;
                    end
                endcase
            end
            2'b01, 2'b11: begin
                c.cmd    = cmd_c(4'b0010);
                c.mem_rd = s;
                c.wb     = s;
                c.mem_wr = !s;
            end
            default: begin
                c.br = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    function automatic logic [REGIDX_W-1:0] first_idx(input logic [NREGS-1:0] m);
        logic [REGIDX_W-1:0] r;
        r = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (m[i]) r = REGIDX_W'(i);
        end
        return r;
    endfunction

    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = rst && !flush && (state_q == IDLE) && slot_free;
    assign accept     = in_valid && in_ready;
    assign rem_after  = rem_q & (rem_q - NREGS'(1));
    assign list_after = reg_list & (reg_list - NREGS'(1));

    always_comb begin
        state_d     = state_q;
        uop_d       = uop_q;
        out_valid_d = out_valid_q;
        rem_d       = rem_q;
        noff_d      = noff_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            rem_d       = '0;
        end else if (state_q == SEQ) begin
            // Control fields persist in uop_q; only index/offset/last advance.
            if (slot_free) begin
                uop_d.reg_idx = first_idx(rem_q);
                uop_d.offs    = noff_q;
                uop_d.last    = (rem_after == '0);
                rem_d         = rem_after;
                noff_d        = noff_q + OFFS_W'(4);
                out_valid_d   = 1'b1;
                if (rem_after == '0) state_d = IDLE;
            end
        end else if (accept) begin
            uop_d.ctrl    = decode(mode, opcode, S);
            uop_d.reg_idx = '0;
            uop_d.offs    = '0;
            uop_d.last    = 1'b1;
            out_valid_d   = 1'b1;
            if (mode == 2'b11) begin
                if (reg_list == '0) begin
                    uop_d.ctrl     = '0;
                    uop_d.ctrl.ill = 1'b1;
                end else begin
                    uop_d.reg_idx = first_idx(reg_list);
                    if (list_after != '0) begin
                        uop_d.last = 1'b0;
                        rem_d      = list_after;
                        noff_d     = OFFS_W'(4);
                        state_d    = SEQ;
                    end
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            uop_q       <= '0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            noff_q      <= '0;
        end else begin
            state_q     <= state_d;
            uop_q       <= uop_d;
            out_valid_q <= out_valid_d;
            rem_q       <= rem_d;
            noff_q      <= noff_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign exeCMD      = uop_q.ctrl.cmd;
    assign S_UpdateSig = uop_q.ctrl.s_upd;
    assign branch      = uop_q.ctrl.br;
    assign memWriteEn  = uop_q.ctrl.mem_wr;
    assign memReadEn   = uop_q.ctrl.mem_rd;
    assign writeBackEn = uop_q.ctrl.wb;
    assign illegal     = uop_q.ctrl.ill;
    assign uop_reg     = uop_q.reg_idx;
    assign uop_offset  = uop_q.offs;
    assign uop_last    = uop_q.last;
    assign busy        = (state_q == SEQ);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: driver pushes expected micro-ops on each accepted
// instruction, monitor pops and compares on every output handshake.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        S;
    logic [15:0] reg_list;
    logic        flush;
    logic        out_valid, out_ready;
    logic [3:0]  exeCMD;
    logic        S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn;
    logic [3:0]  uop_reg;
    logic [7:0]  uop_offset;
    logic        uop_last, illegal, busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] cmd;
        logic       supd, br, mw, mr, wb, ill;
        logic [3:0] rg;
        logic [7:0] off;
        logic       last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .opcode(opcode), .S(S), .reg_list(reg_list), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .exeCMD(exeCMD),
        .S_UpdateSig(S_UpdateSig), .branch(branch), .memWriteEn(memWriteEn),
        .memReadEn(memReadEn), .writeBackEn(writeBackEn), .uop_reg(uop_reg),
        .uop_offset(uop_offset), .uop_last(uop_last), .illegal(illegal), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: instruction -> list of micro-ops, straight from the ISA table.
    task automatic model_push(input logic [1:0] m, input logic [3:0] op, input logic s,
                              input logic [15:0] rl);
        exp_t e;
        int   n, k;
        e = '0;
        e.last = 1'b1;
        if (m == 2'b00) begin
            e.supd = s; e.wb = 1'b1;
            case (op)
                4'hD: e.cmd = 4'h1;   // MOV
                4'hF: e.cmd = 4'h9;   // MVN
                4'h4: e.cmd = 4'h2;   // ADD
                4'h5: e.cmd = 4'h3;   // ADC
                4'h2: e.cmd = 4'h4;   // SUB
                4'h6: e.cmd = 4'h5;   // SBC
                4'h0: e.cmd = 4'h6;   // AND
                4'hC: e.cmd = 4'h7;   // ORR
                4'h1: e.cmd = 4'h8;   // EOR
                4'hA: begin e.cmd = 4'h4; e.supd = 1'b1; e.wb = 1'b0; end
                4'h8: begin e.cmd = 4'h6; e.supd = 1'b1; e.wb = 1'b0; end
                default: begin e.supd = 1'b0; e.wb = 1'b0; e.ill = 1'b1; end
            endcase
            exp_q.push_back(e);
        end else if (m == 2'b10) begin
            e.br = 1'b1;
            exp_q.push_back(e);
        end else if (m == 2'b01) begin
            e.cmd = 4'h2; e.mr = s; e.wb = s; e.mw = !s;
            exp_q.push_back(e);
        end else if (rl == 16'h0) begin
            e.ill = 1'b1;
            exp_q.push_back(e);
        end else begin
            n = $countones(rl);
            k = 0;
            for (int i = 0; i < 16; i++) begin
                if (rl[i]) begin
                    e.cmd = 4'h2; e.mr = s; e.wb = s; e.mw = !s;
                    e.rg = 4'(i);
                    e.off = 8'((4 * k) % 256);
                    e.last = (k == n - 1);
                    exp_q.push_back(e);
                    k++;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                         input logic s, input logic [15:0] rl, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; mode = m; opcode = op; S = s; reg_list = rl;
        out_ready = ordy; flush = fl;
        #1;
        if (in_valid && in_ready) model_push(m, op, s, rl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    initial begin
        exp_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                act = {exeCMD, S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn,
                       illegal, uop_reg, uop_offset, uop_last};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL uop_unexpected: got %h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL uop: got %h expected %h", act, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0]  m;
        logic [15:0] rl;
        int          wait_cyc;
        rst = 1'b0; in_valid = 1'b0; mode = '0; opcode = '0; S = 1'b0;
        reg_list = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {exeCMD, S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn,
                           uop_reg, uop_offset, uop_last, illegal, busy}, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // ADD with S=1, one-cycle latency
        drive(1'b1, 2'b00, 4'b0100, 1'b1, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("add_latency_valid", out_valid, 1);
        chk("add_cmd", {exeCMD, S_UpdateSig, writeBackEn, uop_last}, {4'h2, 3'b111});

        // Undefined opcode then CMP
        drive(1'b1, 2'b00, 4'b0011, 1'b1, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 4'b1010, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("undef_illegal", {out_valid, illegal, exeCMD, S_UpdateSig, writeBackEn}, {2'b11, 6'h0});
        idle(2);

        // LDM 0x8005: busy/in_ready profile over the sequence
        drive(1'b1, 2'b11, 4'h0, 1'b1, 16'h8005, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("ldm_c0", {busy, in_ready, uop_reg}, {2'b10, 4'd0});
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("ldm_c1", {busy, in_ready, uop_reg}, {2'b10, 4'd2});
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("ldm_c2", {busy, in_ready, uop_reg, uop_last}, {2'b01, 4'd15, 1'b1});
        idle(2);

        // STM 0x0003 with a 3-cycle downstream stall after the first micro-op
        drive(1'b1, 2'b11, 4'h0, 1'b0, 16'h0003, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 4'h0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
            chk("stm_hold", {out_valid, uop_reg, uop_offset, uop_last, memWriteEn}, {1'b1, 4'd0, 8'd0, 2'b01});
        end
        idle(3);

        // Flush during second micro-op of LDM 0x00F0
        drive(1'b1, 2'b11, 4'h0, 1'b1, 16'h00F0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 4'b0100, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("flush_in_ready", in_ready, 0);
        drive(1'b0, 2'b00, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("flush_out", {out_valid, busy}, 0);
        exp_q.delete();
        drive(1'b1, 2'b00, 4'b0100, 1'b0, 16'h0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset mid-sequence, then LDM with an empty list
        drive(1'b1, 2'b11, 4'h0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        idle(1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {out_valid, in_ready, busy, exeCMD, memReadEn, writeBackEn,
                          uop_reg, uop_offset, uop_last, illegal}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 2'b11, 4'h0, 1'b1, 16'h0, 1'b1, 1'b0);
        idle(2);

        // Randomised traffic with random back-pressure
        for (int n = 0; n < 600; n++) begin
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rl = 16'(1) << $urandom_range(0, 15);
                1: rl = 16'($urandom);
                default: rl = 16'($urandom & $urandom & $urandom);
            endcase
            drive(($urandom_range(0, 9) < 7), m, 4'($urandom), 1'($urandom), rl,
                  ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Drain with bounded wait
        wait_cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && wait_cyc < 100) begin
            idle(1);
            wait_cyc++;
        end
        chk("drain_timeout", (wait_cyc < 100), 1);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
